// File: rtl/control_unit_pkg.sv
// Shared definitions for the calculator sequencer: key codes, operator and state
// encodings, and a key classifier used by the FSM.
package control_unit_pkg;

    localparam logic [3:0] KEY_ADD   = 4'hA;
    localparam logic [3:0] KEY_SUB   = 4'hB;
    localparam logic [3:0] KEY_MUL   = 4'hC;
    localparam logic [3:0] KEY_DIV   = 4'hD;
    localparam logic [3:0] KEY_EQUAL = 4'hE;
    localparam logic [3:0] KEY_CLEAR = 4'hF;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [2:0] ST_ENTRY_A = 3'd0;
    localparam logic [2:0] ST_OP_WAIT = 3'd1;
    localparam logic [2:0] ST_ENTRY_B = 3'd2;
    localparam logic [2:0] ST_RESULT  = 3'd3;
    localparam logic [2:0] ST_ERROR   = 3'd4;

    typedef enum logic [1:0] {
        KC_DIGIT,
        KC_OP,
        KC_EQUAL,
        KC_CLEAR
    } key_class_e;

    function automatic key_class_e classify_key(input logic [3:0] key);
        key_class_e cls;
        if (key <= 4'h9)
            cls = KC_DIGIT;
        else if (key == KEY_EQUAL)
            cls = KC_EQUAL;
        else if (key == KEY_CLEAR)
            cls = KC_CLEAR;
        else
            cls = KC_OP;
        return cls;
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] key);
        logic [1:0] op;
        case (key)
            KEY_ADD: op = OP_ADD;
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            default: op = OP_DIV;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational unsigned ALU. Add/sub wrap; multiply overflow and divide by zero
// raise o_err and force the result to zero.
module calc_alu
    import control_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err
);

    logic [2*WIDTH-1:0] w_product;

    // Full-width product so overflow is judged on the true product, not a wrapped one.
    assign w_product = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        case (i_op)
            OP_ADD: o_result = i_a + i_b;
            OP_SUB: o_result = i_a - i_b;
            OP_MUL: begin
                if (w_product[2*WIDTH-1:WIDTH] != '0)
                    o_err = 1'b1;
                else
                    o_result = w_product[WIDTH-1:0];
            end
            default: begin
                if (i_b == '0)
                    o_err = 1'b1;
                else
                    o_result = i_a / i_b;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Calculator sequencer: edge-detects key presses, accumulates decimal operands,
// applies the latched operator on '=' or a chained operator, and drives the display.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_ENTRY = 9999
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       button,
    input  logic             is_pressed_next,
    output logic [WIDTH-1:0] display,
    output logic             error,
    output logic [2:0]       o_state
);

    localparam int EW = WIDTH + 4;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [2:0]       r_state;
    logic             r_prev_press;
    logic             r_error;
    logic [WIDTH-1:0] r_display;

    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [1:0]       w_op_nxt;
    logic [2:0]       w_state_nxt;
    logic             w_err_nxt;
    logic [WIDTH-1:0] w_display_nxt;

    logic             w_press;
    key_class_e       w_class;
    logic [1:0]       w_key_op;
    logic [WIDTH-1:0] w_digit;
    logic [EW-1:0]    w_acc_a;
    logic [EW-1:0]    w_acc_b;
    logic             w_a_fits;
    logic             w_b_fits;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_err;

    assign w_press  = is_pressed_next & ~r_prev_press;
    assign w_class  = classify_key(button);
    assign w_key_op = key_to_op(button);
    assign w_digit  = {{(WIDTH-4){1'b0}}, button};

    // Accumulate in a wider field so an oversize entry is rejected rather than wrapped.
    assign w_acc_a  = {4'b0000, r_a} * EW'(10) + EW'(button);
    assign w_acc_b  = {4'b0000, r_b} * EW'(10) + EW'(button);
    assign w_a_fits = (w_acc_a <= EW'(MAX_ENTRY));
    assign w_b_fits = (w_acc_b <= EW'(MAX_ENTRY));

    calc_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_alu_result),
        .o_err    (w_alu_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_op_nxt    = r_op;
        w_err_nxt   = r_error;
        if (w_press) begin
            if (w_class == KC_CLEAR) begin
                w_state_nxt = ST_ENTRY_A;
                w_a_nxt     = '0;
                w_b_nxt     = '0;
                w_op_nxt    = OP_ADD;
                w_err_nxt   = 1'b0;
            end else begin
                case (r_state)
                    ST_ENTRY_A: begin
                        if (w_class == KC_DIGIT) begin
                            if (w_a_fits)
                                w_a_nxt = w_acc_a[WIDTH-1:0];
                        end else if (w_class == KC_OP) begin
                            w_op_nxt    = w_key_op;
                            w_b_nxt     = '0;
                            w_state_nxt = ST_OP_WAIT;
                        end
                    end
                    ST_OP_WAIT: begin
                        if (w_class == KC_DIGIT) begin
                            w_b_nxt     = w_digit;
                            w_state_nxt = ST_ENTRY_B;
                        end else if (w_class == KC_OP) begin
                            w_op_nxt = w_key_op;
                        end
                    end
                    ST_ENTRY_B: begin
                        if (w_class == KC_DIGIT) begin
                            if (w_b_fits)
                                w_b_nxt = w_acc_b[WIDTH-1:0];
                        end else if (w_alu_err) begin
                            w_a_nxt     = '0;
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_ERROR;
                        end else begin
                            w_a_nxt = w_alu_result;
                            if (w_class == KC_EQUAL) begin
                                w_state_nxt = ST_RESULT;
                            end else begin
                                w_op_nxt    = w_key_op;
                                w_b_nxt     = '0;
                                w_state_nxt = ST_OP_WAIT;
                            end
                        end
                    end
                    ST_RESULT: begin
                        if (w_class == KC_DIGIT) begin
                            w_a_nxt     = w_digit;
                            w_state_nxt = ST_ENTRY_A;
                        end else if (w_class == KC_OP) begin
                            w_op_nxt    = w_key_op;
                            w_b_nxt     = '0;
                            w_state_nxt = ST_OP_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Display follows the state being entered so it changes on the same edge as the key.
    always_comb begin
        case (w_state_nxt)
            ST_ENTRY_B: w_display_nxt = w_b_nxt;
            ST_ERROR:   w_display_nxt = '0;
            default:    w_display_nxt = w_a_nxt;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= OP_ADD;
            r_state      <= ST_ENTRY_A;
            r_prev_press <= 1'b0;
            r_error      <= 1'b0;
            r_display    <= '0;
        end else begin
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_op         <= w_op_nxt;
            r_state      <= w_state_nxt;
            r_prev_press <= is_pressed_next;
            r_error      <= w_err_nxt;
            r_display    <= w_display_nxt;
        end
    end

    assign display = r_display;
    assign error   = r_error;
    assign o_state = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed calculator scenarios followed by random key
// sequences, all checked against a behavioural calculator model.
module tb_control_unit;
    import control_unit_pkg::*;

    localparam int WIDTH     = 16;
    localparam int MAX_ENTRY = 9999;
    localparam longint MODULUS = 65536;

    logic             clock;
    logic             reset;
    logic [3:0]       button;
    logic             is_pressed_next;
    logic [WIDTH-1:0] display;
    logic             error;
    logic [2:0]       o_state;

    int checks = 0;
    int errors = 0;

    typedef enum {M_A, M_OPW, M_B, M_RES, M_ERR} mstate_e;
    mstate_e     m_st;
    longint      m_a;
    longint      m_b;
    int          m_op;
    bit          m_err;

    control_unit #(
        .WIDTH     (WIDTH),
        .MAX_ENTRY (MAX_ENTRY)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .button          (button),
        .is_pressed_next (is_pressed_next),
        .display         (display),
        .error           (error),
        .o_state         (o_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_st = M_A; m_a = 0; m_b = 0; m_op = 0; m_err = 1'b0;
    endfunction

    // Returns -1 when the operation is illegal (div by zero, product too large).
    function automatic longint model_alu(input longint x, input int op, input longint y);
        longint r;
        case (op)
            0: r = (x + y) % MODULUS;
            1: r = (x - y + MODULUS) % MODULUS;
            2: r = (x * y >= MODULUS) ? -1 : x * y;
            default: r = (y == 0) ? -1 : x / y;
        endcase
        return r;
    endfunction

    function automatic void model_key(input int k);
        longint r;
        if (k == 15) begin
            model_reset();
            return;
        end
        case (m_st)
            M_A: begin
                if (k <= 9) begin
                    if (m_a * 10 + k <= MAX_ENTRY) m_a = m_a * 10 + k;
                end else if (k <= 13) begin
                    m_op = k - 10; m_b = 0; m_st = M_OPW;
                end
            end
            M_OPW: begin
                if (k <= 9) begin
                    m_b = k; m_st = M_B;
                end else if (k <= 13) begin
                    m_op = k - 10;
                end
            end
            M_B: begin
                if (k <= 9) begin
                    if (m_b * 10 + k <= MAX_ENTRY) m_b = m_b * 10 + k;
                end else begin
                    r = model_alu(m_a, m_op, m_b);
                    if (r < 0) begin
                        m_a = 0; m_err = 1'b1; m_st = M_ERR;
                    end else begin
                        m_a = r;
                        if (k == 14) m_st = M_RES;
                        else begin
                            m_op = k - 10; m_b = 0; m_st = M_OPW;
                        end
                    end
                end
            end
            M_RES: begin
                if (k <= 9) begin
                    m_a = k; m_st = M_A;
                end else if (k <= 13) begin
                    m_op = k - 10; m_b = 0; m_st = M_OPW;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic longint model_display();
        if (m_st == M_B) return m_b;
        if (m_st == M_ERR) return 0;
        return m_a;
    endfunction

    function automatic logic [2:0] model_state_code();
        case (m_st)
            M_A:     return ST_ENTRY_A;
            M_OPW:   return ST_OP_WAIT;
            M_B:     return ST_ENTRY_B;
            M_RES:   return ST_RESULT;
            default: return ST_ERROR;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".display"}, longint'(display), model_display());
        check({tag, ".error"}, longint'(error), longint'(m_err));
        check({tag, ".state"}, longint'(o_state), longint'(model_state_code()));
    endtask

    // ---------------- driver ----------------
    task automatic press(input int k, input int hold);
        @(negedge clock);
        button = 4'(k);
        is_pressed_next = 1'b1;
        repeat (hold) @(negedge clock);
        is_pressed_next = 1'b0;
        button = 4'($urandom_range(0, 15));
        model_key(k);
        check_model($sformatf("key%0d", k));
    endtask

    task automatic press_seq(input int keys[$]);
        foreach (keys[i]) press(keys[i], 1);
    endtask

    initial begin
        int r;
        int k;
        reset = 1'b0;
        button = 4'h0;
        is_pressed_next = 1'b0;
        model_reset();
        #1;
        check("reset.display", longint'(display), 0);
        check("reset.error", longint'(error), 0);
        check("reset.state", longint'(o_state), longint'(ST_ENTRY_A));
        #9;
        reset = 1'b1;

        // 1: simple entry and clear
        press_seq('{15, 8, 9});
        check("t1.display89", longint'(display), 89);
        press(15, 1);
        check("t1.clear", longint'(display), 0);

        // 2: held operator strobe latches once
        press(3, 1);
        press(10, 2);
        check("t2.opwait", longint'(display), 3);
        press(2, 1);
        check("t2.b", longint'(display), 2);
        press(14, 1);
        check("t2.sum", longint'(display), 5);

        // 3: divide then reuse result
        press_seq('{15, 7, 13, 4, 14});
        check("t3.div", longint'(display), 1);
        press_seq('{10, 7, 14});
        check("t3.reuse", longint'(display), 8);

        // 4: divide by zero is sticky until clear
        press_seq('{15, 5, 13, 0, 14});
        check("t4.err", longint'(error), 1);
        check("t4.disp", longint'(display), 0);
        press_seq('{3, 10, 4, 14});
        check("t4.sticky", longint'(error), 1);
        press(15, 1);
        check("t4.cleared", longint'(error), 0);

        // 5: entry limit, subtract wrap, multiply overflow
        press_seq('{9, 9, 9, 9, 9});
        check("t5.max", longint'(display), 9999);
        press_seq('{15, 2, 11, 5, 14});
        check("t5.wrap", longint'(display), 65533);
        press_seq('{15, 3, 0, 0, 12, 3, 0, 0, 14});
        check("t5.ovf", longint'(error), 1);

        // 6: chaining, then reset mid-entry of b
        press_seq('{15, 2, 10, 3, 12, 4, 14});
        check("t6.chain", longint'(display), 20);
        press_seq('{15, 1, 10, 4});
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_reset();
        check("t6.rst.display", longint'(display), 0);
        check("t6.rst.state", longint'(o_state), longint'(ST_ENTRY_A));
        repeat (2) @(negedge clock);
        // Strobe already high when reset releases: the next edge is a fresh press.
        button = 4'h7;
        is_pressed_next = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        is_pressed_next = 1'b0;
        model_key(7);
        check_model("t6.post_reset");
        check("t6.post_reset7", longint'(display), 7);

        // Random key sequences with varying hold lengths
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      k = $urandom_range(0, 9);
            else if (r < 77) k = 10 + $urandom_range(0, 3);
            else if (r < 93) k = 14;
            else             k = 15;
            press(k, $urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
